// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: packet-granular round-robin mux of N_SRC AXI-Stream sources onto one registered output.
module axis_rr_arbiter #(
  parameter int N_SRC  = 3,
  parameter int DATA_W = 32,
  parameter int ID_W   = 2
) (
  input  logic                      axi_aclk,
  input  logic                      axi_areset,
  input  logic [N_SRC-1:0]          src_en,
  input  logic [N_SRC-1:0]          s_tvalid,
  input  logic [N_SRC*DATA_W-1:0]   s_tdata,
  input  logic [N_SRC*DATA_W/8-1:0] s_tstrb,
  input  logic [N_SRC*DATA_W/8-1:0] s_tkeep,
  input  logic [N_SRC-1:0]          s_tlast,
  input  logic [N_SRC*2-1:0]        s_tuser,
  output logic [N_SRC-1:0]          s_tready,
  output logic                      m_tvalid,
  output logic [DATA_W-1:0]         m_tdata,
  output logic [DATA_W/8-1:0]       m_tstrb,
  output logic [DATA_W/8-1:0]       m_tkeep,
  output logic                      m_tlast,
  output logic [1:0]                m_tuser,
  output logic [ID_W-1:0]           m_tid,
  input  logic                      m_tready,
  output logic [ID_W-1:0]           grant_id,
  output logic                      busy
);
  localparam int SW = DATA_W / 8;
  typedef enum logic {IDLE, XFER} state_t;
  state_t          state;
  logic [ID_W-1:0] rr_ptr, win;
  logic            found, ready, accept;
  int              idx;
  // first enabled requester at or after rr_ptr, wrapping modulo N_SRC
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < N_SRC; k++) begin
      idx = int'(rr_ptr) + k;
      idx = idx >= N_SRC ? idx - N_SRC : idx;
      if (!found && s_tvalid[idx] && src_en[idx]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
  end
  assign busy     = state == XFER;
  assign ready    = busy & (~m_tvalid | m_tready);
  assign accept   = ready & s_tvalid[grant_id];
  assign s_tready = ready ? N_SRC'(1) << grant_id : '0;
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tstrb  <= '0;
      m_tkeep  <= '0;
      m_tlast  <= 1'b0;
      m_tuser  <= '0;
      m_tid    <= '0;
    end else begin
      if (m_tready) m_tvalid <= 1'b0;
      if (state == IDLE && found) begin
        grant_id <= win;
        state    <= XFER;
      end
      if (accept) begin
        m_tvalid <= 1'b1;
        m_tdata  <= s_tdata[int'(grant_id)*DATA_W +: DATA_W];
        m_tstrb  <= s_tstrb[int'(grant_id)*SW +: SW];
        m_tkeep  <= s_tkeep[int'(grant_id)*SW +: SW];
        m_tlast  <= s_tlast[grant_id];
        m_tuser  <= s_tuser[int'(grant_id)*2 +: 2];
        m_tid    <= grant_id;
        if (s_tlast[grant_id]) begin
          state  <= IDLE;
          rr_ptr <= int'(grant_id) == N_SRC - 1 ? '0 : grant_id + 1'b1;
        end
      end
    end
  end
endmodule
